// File: rtl/jericalla_pkg.sv
// Shared constants and types for the jericalla instruction sequencer.
// Holds bus/buffer widths, instruction field positions and the fetch FSM state type.
package jericalla_pkg;

  localparam int unsigned INSTR_W = 17;
  localparam int unsigned DEPTH   = 16;
  localparam int unsigned ADDR_W  = 4;

  // Instruction field layout as consumed by the datapath.
  localparam int unsigned RAM_ADDR_MSB = 16;
  localparam int unsigned RAM_ADDR_LSB = 13;
  localparam int unsigned OP_MSB       = 12;
  localparam int unsigned OP_LSB       = 9;
  localparam int unsigned RS1_MSB      = 8;
  localparam int unsigned RS1_LSB      = 5;
  localparam int unsigned RS2_MSB      = 4;
  localparam int unsigned RS2_LSB      = 1;
  localparam int unsigned WEN_BIT      = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/instr_mem.sv
// Program buffer: DEPTH x INSTR_W storage, one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset.
// Ports:
//   clk         clock
//   wr_en       write strobe
//   wr_addr     write address
//   wr_data     data written at the rising edge
//   rd_addr     read address
//   rd_data     combinational read data
module instr_mem
  import jericalla_pkg::*;
(
  input  logic               clk,
  input  logic               wr_en,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [INSTR_W-1:0] wr_data,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic [INSTR_W-1:0] rd_data
);

  logic [INSTR_W-1:0] mem [DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read port.
  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/jericalla_fetch.sv
// Instruction sequencer feeding the jericalla datapath. Programs are loaded into
// a 16-entry buffer, then issued one per clock from address 0 to a latched last
// address, with optional early halt on the datapath's ZF flag.
// Ports:
//   clk, reset      clock and synchronous active-high reset
//   load_en/addr/data  program buffer write port (dropped while running)
//   load_err        one-cycle pulse when a load was dropped during RUN
//   start, stop     begin at address 0 / abort execution
//   last_addr       final address to execute (latched on start)
//   halt_on_zf      enable ZF early halt (latched on start)
//   zf_in           ZF from the datapath for the issued instruction
//   instruction     registered instruction bus, zero when not valid
//   instr_valid     instruction holds a live issued instruction
//   pc              address of the next instruction to fetch
//   busy, done      state decodes (RUN, DONE)
module jericalla_fetch
  import jericalla_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load_en,
  input  logic [ADDR_W-1:0]  load_addr,
  input  logic [INSTR_W-1:0] load_data,
  output logic               load_err,
  input  logic               start,
  input  logic               stop,
  input  logic [ADDR_W-1:0]  last_addr,
  input  logic               halt_on_zf,
  input  logic               zf_in,
  output logic [INSTR_W-1:0] instruction,
  output logic               instr_valid,
  output logic [ADDR_W-1:0]  pc,
  output logic               busy,
  output logic               done
);

  fetch_state_t       state, state_n;
  logic [ADDR_W-1:0]  pc_n;
  logic [INSTR_W-1:0] instr_n;
  logic               valid_n;
  logic [ADDR_W-1:0]  last_q, last_n;
  logic               hz_q, hz_n;
  logic               load_err_n;
  logic               mem_we;
  logic [INSTR_W-1:0] mem_rd;

  instr_mem u_mem (
    .clk     (clk),
    .wr_en   (mem_we),
    .wr_addr (load_addr),
    .wr_data (load_data),
    .rd_addr (pc),
    .rd_data (mem_rd)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= '0;
      instruction <= '0;
      instr_valid <= 1'b0;
      last_q      <= '0;
      hz_q        <= 1'b0;
      load_err    <= 1'b0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      instruction <= instr_n;
      instr_valid <= valid_n;
      last_q      <= last_n;
      hz_q        <= hz_n;
      load_err    <= load_err_n;
    end
  end

  // Next-state and next-register logic.
  always_comb begin
    state_n    = state;
    pc_n       = pc;
    instr_n    = instruction;
    valid_n    = instr_valid;
    last_n     = last_q;
    hz_n       = hz_q;
    load_err_n = 1'b0;
    mem_we     = 1'b0;

    case (state)
      IDLE, DONE: begin
        // Bus is cleared one edge after the final issue so wEn never lingers.
        instr_n = '0;
        valid_n = 1'b0;
        mem_we  = load_en;
        if (start && !stop) begin
          state_n = RUN;
          pc_n    = '0;
          last_n  = last_addr;
          hz_n    = halt_on_zf;
        end
      end
      RUN: begin
        load_err_n = load_en;
        if (stop) begin
          state_n = IDLE;
          instr_n = '0;
          valid_n = 1'b0;
        end else if (hz_q && instr_valid && zf_in) begin
          state_n = DONE;
          instr_n = '0;
          valid_n = 1'b0;
        end else begin
          instr_n = mem_rd;
          valid_n = 1'b1;
          if (pc == last_q) begin
            state_n = DONE;
          end else begin
            pc_n = pc + ADDR_W'(1);
          end
        end
      end
      default: begin
        state_n = IDLE;
        instr_n = '0;
        valid_n = 1'b0;
      end
    endcase
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_jericalla_fetch.sv
// Randomized self-checking bench for jericalla_fetch. A reference model derives,
// for each run, how many instructions should be issued and where the run ends,
// from the program array, last address, stop cycle and ZF cycle.
module tb_jericalla_fetch;
  import jericalla_pkg::*;

  logic               clk = 1'b0;
  logic               reset;
  logic               load_en;
  logic [ADDR_W-1:0]  load_addr;
  logic [INSTR_W-1:0] load_data;
  logic               load_err;
  logic               start;
  logic               stop;
  logic [ADDR_W-1:0]  last_addr;
  logic               halt_on_zf;
  logic               zf_in;
  logic [INSTR_W-1:0] instruction;
  logic               instr_valid;
  logic [ADDR_W-1:0]  pc;
  logic               busy;
  logic               done;

  int checks = 0;
  int errors = 0;
  logic [INSTR_W-1:0] mem_m [DEPTH];

  always #5 clk = ~clk;

  jericalla_fetch dut (
    .clk         (clk),
    .reset       (reset),
    .load_en     (load_en),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .load_err    (load_err),
    .start       (start),
    .stop        (stop),
    .last_addr   (last_addr),
    .halt_on_zf  (halt_on_zf),
    .zf_in       (zf_in),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .pc          (pc),
    .busy        (busy),
    .done        (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int addr, input logic [INSTR_W-1:0] data);
    load_en   = 1'b1;
    load_addr = ADDR_W'(addr);
    load_data = data;
    mem_m[addr] = data;
    tick();
    load_en = 1'b0;
  endtask

  // One program run. z: valid cycle (1-based) with zf_in=1, s: valid cycle with
  // stop=1, ld: valid cycle with a load attempt to addr 3 (0 = none).
  task automatic run_prog(input int last, input bit hz, input int z, input int s,
                          input int ld, input bit ld0, input bit rnd_start);
    int n, issued, pc_e, exp_pc;
    bit to_idle, exp_v;
    logic [INSTR_W-1:0] d, exp_i;
    n = last + 1;
    issued = n;
    pc_e = last;
    to_idle = 1'b0;
    if (s > 0 && s < n) begin
      issued = s;
      pc_e = s;
      to_idle = 1'b1;
    end else if (hz && z > 0 && z < n) begin
      issued = z;
      pc_e = z;
    end

    if (ld0) begin
      d = INSTR_W'($urandom);
      mem_m[0] = d;
      load_en = 1'b1;
      load_addr = '0;
      load_data = d;
    end
    start = 1'b1;
    last_addr = ADDR_W'(last);
    halt_on_zf = hz;
    tick();
    start = 1'b0;
    load_en = 1'b0;
    last_addr = ADDR_W'($urandom);
    halt_on_zf = 1'($urandom);
    check("start_busy", 32'(busy), 32'd1);
    check("start_valid", 32'(instr_valid), 32'd0);

    for (int c = 1; c <= n + 2; c++) begin
      tick();
      exp_v = (c <= issued);
      exp_i = exp_v ? mem_m[c-1] : '0;
      exp_pc = (c <= issued) ? ((c <= last) ? c : last) : pc_e;
      check($sformatf("valid_c%0d", c), 32'(instr_valid), 32'(exp_v));
      check($sformatf("instr_c%0d", c), 32'(instruction), 32'(exp_i));
      check($sformatf("pc_c%0d", c), 32'(pc), 32'(exp_pc));
      check($sformatf("lderr_c%0d", c), 32'(load_err), 32'(ld > 0 && c == ld + 1));
      zf_in = hz ? (c == z) : 1'($urandom);
      stop = (c == s);
      start = (rnd_start && c < issued) ? 1'($urandom) : 1'b0;
      load_en = (c == ld);
      load_addr = ADDR_W'(3);
      load_data = INSTR_W'($urandom);
    end
    stop = 1'b0;
    zf_in = 1'b0;
    start = 1'b0;
    load_en = 1'b0;
    check("end_busy", 32'(busy), 32'd0);
    check("end_done", 32'(done), 32'(!to_idle));
    check("end_pc", 32'(pc), 32'(pc_e));
  endtask

  initial begin
    int l, mode;
    reset = 1'b1;
    load_en = 1'b0;
    load_addr = '0;
    load_data = '0;
    start = 1'b0;
    stop = 1'b0;
    last_addr = '0;
    halt_on_zf = 1'b0;
    zf_in = 1'b0;
    tick();
    tick();
    check("rst_instr", 32'(instruction), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_lderr", 32'(load_err), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < int'(DEPTH); i++) load(i, INSTR_W'($urandom));
    load(0, 17'h1A2B3);
    load(1, 17'h00F01);
    load(2, 17'h10000);

    // Three-instruction program.
    run_prog(2, 1'b0, 0, 0, 0, 1'b0, 1'b0);
    // Stop in DONE has no effect.
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop_in_done", 32'(done), 32'd1);

    // Single instruction.
    run_prog(0, 1'b0, 0, 0, 0, 1'b0, 1'b0);
    // Full program aborted after the 5th issue, with starts thrown in while running.
    run_prog(15, 1'b0, 0, 5, 0, 1'b0, 1'b1);
    // Start and stop together in IDLE: stays IDLE.
    start = 1'b1;
    stop = 1'b1;
    tick();
    start = 1'b0;
    stop = 1'b0;
    tick();
    check("startstop_busy", 32'(busy), 32'd0);
    check("startstop_valid", 32'(instr_valid), 32'd0);
    // ZF halt on the 2nd issue.
    run_prog(15, 1'b1, 2, 0, 0, 1'b0, 1'b0);
    // Dropped load during RUN, then rerun shows original mem[3].
    run_prog(7, 1'b0, 0, 0, 2, 1'b0, 1'b0);
    run_prog(7, 1'b0, 0, 0, 0, 1'b0, 1'b0);
    // Load coinciding with start is visible to the first fetch.
    run_prog(3, 1'b0, 0, 0, 0, 1'b1, 1'b0);

    // Synchronous reset mid-run; buffer survives.
    start = 1'b1;
    last_addr = ADDR_W'(15);
    tick();
    start = 1'b0;
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_valid", 32'(instr_valid), 32'd0);
    check("midrst_instr", 32'(instruction), 32'd0);
    check("midrst_pc", 32'(pc), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    run_prog(15, 1'b0, 0, 0, 0, 1'b0, 1'b0);

    // Randomized runs.
    for (int r = 0; r < 10; r++) begin
      if ($urandom_range(0, 1) == 1) load($urandom_range(0, 15), INSTR_W'($urandom));
      l = $urandom_range(0, 15);
      mode = $urandom_range(0, 2);
      if (mode == 1)
        run_prog(l, 1'b0, 0, $urandom_range(1, l + 3), 0, 1'b0, 1'b1);
      else if (mode == 2)
        run_prog(l, 1'b1, $urandom_range(1, l + 2), 0, 0, 1'b0, 1'b0);
      else
        run_prog(l, 1'b0, 0, 0, 0, 1'($urandom), 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jericalla_fetch.md
Name: jericalla_fetch

Overview:
- Instruction sequencer directly upstream of the jericalla datapath; drives its 17-bit instruction bus.
- Holds a 16-entry program buffer, loaded through a simple write port, then issues one instruction per clock from address 0 to a programmed last address.
- Optional early halt when the datapath's ZF output is asserted.
- When nothing is issued, the instruction bus carries all-zero, so wEn (bit 0) is 0 and RAM is never written spuriously.

Parameters:
- INSTR_W, 17, instruction width (fields: [16:13] RAM addr, [12:9] op, [8:5] rs1, [4:1] rs2, [0] wEn).
- DEPTH, 16, program buffer entries.
- ADDR_W, 4, log2(DEPTH); width of pc, load_addr and last_addr.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- load_en  in  1  write strobe for the program buffer.
- load_addr  in  ADDR_W  buffer write address.
- load_data  in  INSTR_W  instruction to store.
- load_err  out  1  one-cycle pulse: load_en was asserted while RUN, and the write was dropped.
- start  in  1  begin execution at address 0.
- stop  in  1  abort execution.
- last_addr  in  ADDR_W  final address to execute; latched on start.
- halt_on_zf  in  1  enables the ZF early halt; latched on start.
- zf_in  in  1  ZF from the datapath for the currently issued instruction.
- instruction  out  INSTR_W  registered instruction to the datapath; 0 when instr_valid=0.
- instr_valid  out  1  instruction holds a live issued instruction.
- pc  out  ADDR_W  address of the next instruction to fetch.
- busy  out  1  state == RUN.
- done  out  1  state == DONE (level).

Behaviour:
- States: IDLE, RUN, DONE. Reset → IDLE.
- Reset values: instruction=0, instr_valid=0, pc=0, busy=0, done=0, load_err=0, latched last_addr=0, latched halt_on_zf=0.
- Buffer contents are not reset; a reset mid-run leaves the buffer intact.
- Load:
  - In IDLE or DONE, load_en writes load_data to mem[load_addr] at the edge.
  - In RUN, the write is ignored and load_err=1 for the following cycle.
- IDLE/DONE + start=1, stop=0, at an edge:
  - state←RUN, pc←0, latch last_addr and halt_on_zf.
  - A load at the same edge is visible to the first fetch (the first read happens at the next edge).
- RUN, at each edge (priority order):
  1. stop=1: state←IDLE, instr_valid←0, instruction←0, pc unchanged.
  2. latched halt_on_zf && instr_valid && zf_in: state←DONE, instr_valid←0, instruction←0. The instruction that produced ZF was already issued; nothing further is issued.
  3. Otherwise: instruction←mem[pc], instr_valid←1. If pc==latched last_addr, state←DONE; else pc←pc+1.
- DONE, at the next edge: instr_valid←0, instruction←0.
- Latency: start sampled at edge N → mem[0] valid after edge N+1 → mem[k] valid after edge N+1+k. instr_valid is high for exactly last_addr+1 cycles when there is no stop or ZF halt.
- Boundaries:
  - last_addr=0: exactly one instruction issued.
  - last_addr=15: pc reaches 15 and stops; pc never wraps.
  - start while RUN: ignored.
  - start and stop together in IDLE: stop wins, stay IDLE.
  - stop in IDLE/DONE: no effect.
- busy and done are combinational decodes of the state register.

Decomposition:
- Package jericalla_pkg holds:
  - INSTR_W, ADDR_W, DEPTH.
  - Field-position constants: RAM_ADDR_MSB/LSB, OP_MSB/LSB, RS1_MSB/LSB, RS2_MSB/LSB, WEN_BIT.
  - State enum fetch_state_t {IDLE, RUN, DONE}.
- One sub-module: instr_mem. DEPTH×INSTR_W storage, one synchronous write port, one asynchronous read port, no reset.

Test Plan:
- Reset, then load mem[0..2]={17'h1A2B3,17'h00F01,17'h10000}, last_addr=2, start → instr_valid high 3 cycles carrying those values in order; then done=1, instruction=0, pc=2.
- last_addr=0, start → exactly one valid cycle with mem[0]; DONE on the same edge.
- last_addr=15, full program, assert stop after the 5th valid cycle → instr_valid=0 next cycle; state IDLE, pc=5, done=0.
- halt_on_zf=1, zf_in forced 1 during the 2nd valid cycle → only 2 instructions issued, then done=1.
- load_en during RUN to addr 3 → load_err pulses 1 cycle; a rerun issues the original mem[3].
- Synchronous reset asserted mid-RUN → next cycle IDLE, instr_valid=0, pc=0; rerun with no reload reproduces the previous program.
